arb8way16: RTL

ARB8WAY16 -- requirements
Module: arb8way16

---
 rtl/arb8way16.sv | 134 +++++++++++++
 1 files changed

// File: rtl/arb8way16.sv
// Round-robin arbiter: 8 requesters onto one 16-bit bus, bursts up to BURST beats per grant.
// Latency: grant one edge after req seen in IDLE; out is combinational from a..h via registered sel.
// Backpressure: out_ready=0 freezes grant, beat count and sel; out keeps tracking the selected input.

module mux8way16 (
  input  logic [2:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [15:0] out
);
  // Pure 8:1 select of the data words
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end
endmodule

module arb8way16 #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        out_valid,
  output logic [7:0]  gnt,
  output logic [2:0]  sel,
  output logic        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] beat;
  logic [2:0] winner;
  logic       found;
  logic       fire;
  logic       last_beat;

  mux8way16 u_mux (
    .sel (sel),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .out (out)
  );

  assign busy      = (state == GRANT);
  assign out_valid = busy && req[sel];
  assign fire      = out_valid && out_ready;
  assign last_beat = (beat == 4'(BURST - 1));

  // First asserted request searching upward from ptr, wrapping 7->0
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Arbitration FSM; sel survives release so the bus keeps showing the last owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 8'h00;
      sel   <= 3'd0;
      ptr   <= 3'd0;
      beat  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            gnt   <= 8'(1) << winner;
            sel   <= winner;
            beat  <= 4'd0;
          end
        end
        GRANT: begin
          if (!req[sel] || (fire && last_beat)) begin
            state <= IDLE;
            gnt   <= 8'h00;
            beat  <= 4'd0;
            ptr   <= sel + 3'd1;
          end else if (fire) begin
            beat <= beat + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'h00;
        end
      endcase
    end
  end

endmodule
